// File: rtl/npc_mem_pkg.sv
// Shared types and default widths for the IFU/LSU memory arbiter.
package npc_mem_pkg;

    localparam int MEM_ADDR_W = 64;
    localparam int MEM_DATA_W = 64;

    // IDLE: accept a request; ISSUE: present it to memory; WAIT: await the response
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between IFU and LSU.
// On a tie the requester that was not granted last wins; driving
// last_grant with a constant OWN_IFU gives fixed LSU priority.
module mem_arb_pick
    import npc_mem_pkg::*;
(
    input  logic   ifu_valid,
    input  logic   lsu_valid,
    input  owner_e last_grant,
    output owner_e winner
);

    // Tie goes to whoever did not win last; otherwise whoever is asking
    always_comb begin
        winner = OWN_LSU;
        if (ifu_valid && lsu_valid)
            winner = (last_grant == OWN_LSU) ? OWN_IFU : OWN_LSU;
        else if (ifu_valid)
            winner = OWN_IFU;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (IFU fetch / LSU load-store) arbiter onto a single memory
// port, one transaction outstanding. Optional feature: define
// MEM_ARB_ROUND_ROBIN_EN for round-robin tie breaking instead of fixed
// LSU priority.
module mem_arbiter
    import npc_mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    // fetch port (read only)
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_W-1:0]   ifu_rdata,
    // load/store port
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_we,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,
    // memory port
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_we,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int MASK_W = DATA_W / 8;

    state_e              state_q, state_d;
    owner_e              owner_q;
    owner_e              winner;
    owner_e              last_grant;
    logic                grant;
    logic                resp_fire;
    logic [ADDR_W-1:0]   addr_q;
    logic                we_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [MASK_W-1:0]   wmask_q;

    // No grant while reset is held, so a requester never sees a ready that is dropped
    assign grant     = (state_q == IDLE) && (ifu_req_valid || lsu_req_valid) && !rst;
    assign resp_fire = (state_q == WAIT) && mem_resp_valid;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    owner_e last_grant_q;

    // Remember the most recent winner; starts at IFU so the LSU wins the first tie
    always_ff @(posedge clk) begin
        if (rst)
            last_grant_q <= OWN_IFU;
        else if (grant)
            last_grant_q <= winner;
    end

    assign last_grant = last_grant_q;
`else
    // Pinned to IFU: every tie then resolves to the LSU
    assign last_grant = OWN_IFU;
`endif

    mem_arb_pick u_pick (
        .ifu_valid  (ifu_req_valid),
        .lsu_valid  (lsu_req_valid),
        .last_grant (last_grant),
        .winner     (winner)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state: stray responses outside WAIT are ignored
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant)         state_d = ISSUE;
            ISSUE:   if (mem_req_ready) state_d = WAIT;
            WAIT:    if (mem_resp_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture the winning request and its owner at grant; fetches carry no write data
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= OWN_LSU;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else if (grant) begin
            owner_q <= winner;
            if (winner == OWN_LSU) begin
                addr_q  <= lsu_addr;
                we_q    <= lsu_we;
                wdata_q <= lsu_wdata;
                wmask_q <= lsu_wmask;
            end else begin
                addr_q  <= ifu_addr;
                we_q    <= 1'b0;
                wdata_q <= '0;
                wmask_q <= '0;
            end
        end
    end

    // Outputs: ready only at grant, memory fields from the latch, response routed to owner
    always_comb begin
        ifu_req_ready  = grant && (winner == OWN_IFU);
        lsu_req_ready  = grant && (winner == OWN_LSU);
        mem_req_valid  = (state_q == ISSUE);
        mem_addr       = addr_q;
        mem_we         = we_q;
        mem_wdata      = wdata_q;
        mem_wmask      = wmask_q;
        ifu_resp_valid = resp_fire && (owner_q == OWN_IFU);
        lsu_resp_valid = resp_fire && (owner_q == OWN_LSU);
        ifu_rdata      = ifu_resp_valid ? mem_rdata : '0;
        lsu_rdata      = lsu_resp_valid ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed stimulus pushes expected
// responses into a queue; a negedge monitor pops and compares them.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
    logic [63:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_we, lsu_resp_valid;
    logic [63:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [7:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_we, mem_resp_valid;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;

    typedef struct {
        bit          is_lsu;
        logic [63:0] data;
        bit          chk_data;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_addr       (ifu_addr),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_rdata      (ifu_rdata),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_addr       (lsu_addr),
        .lsu_we         (lsu_we),
        .lsu_wdata      (lsu_wdata),
        .lsu_wmask      (lsu_wmask),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_rdata      (lsu_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_we         (mem_we),
        .mem_wdata      (mem_wdata),
        .mem_wmask      (mem_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit is_lsu, input logic [63:0] d, input bit chk);
        exp_t e;
        e.is_lsu = is_lsu;
        e.data = d;
        e.chk_data = chk;
        exp_q.push_back(e);
    endtask

    task automatic chk_mem(input logic [63:0] a, input logic w, input logic [63:0] d,
                           input logic [7:0] m);
        check("mem_req_valid", mem_req_valid, 1);
        check("mem_addr", mem_addr, a);
        check("mem_we", mem_we, w);
        check("mem_wdata", mem_wdata, d);
        check("mem_wmask", mem_wmask, m);
    endtask

    // Called at the first ISSUE cycle: stall, accept, then respond with rd
    task automatic do_mem(input int stall, input logic [63:0] a, input logic w,
                          input logic [63:0] d, input logic [7:0] m, input logic [63:0] rd);
        mem_req_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            #1 chk_mem(a, w, d, m);
            check("no_ready_in_issue", {ifu_req_ready, lsu_req_ready}, 0);
            tick();
        end
        mem_req_ready = 1'b1;
        #1 chk_mem(a, w, d, m);
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = rd;
        #1 check("wait_mem_valid_low", mem_req_valid, 0);
        tick();
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (ifu_resp_valid && lsu_resp_valid) begin
            check("dual_resp", 1, 0);
        end else if (ifu_resp_valid || lsu_resp_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("resp_owner_is_lsu", lsu_resp_valid, e.is_lsu);
                if (e.chk_data)
                    check("resp_rdata", lsu_resp_valid ? lsu_rdata : ifu_rdata, e.data);
            end
        end
        if (mem_resp_valid) begin
            if (!ifu_resp_valid) check("ifu_rdata_idle_zero", ifu_rdata, 0);
            if (!lsu_resp_valid) check("lsu_rdata_idle_zero", lsu_rdata, 0);
        end
    end

    initial begin
        bit exp_lsu;
        rst = 1'b1;
        ifu_req_valid = 0; ifu_addr = '0;
        lsu_req_valid = 0; lsu_addr = '0; lsu_we = 0; lsu_wdata = '0; lsu_wmask = '0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_mem_req_valid", mem_req_valid, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_fields", {mem_we, mem_wmask, mem_wdata}, 0);
        check("rst_readies", {ifu_req_ready, lsu_req_ready}, 0);
        tick();

        // IFU-only read, 3-cycle transaction
        ifu_req_valid = 1; ifu_addr = 64'h8000_0000;
        #1 check("ifu_ready", {ifu_req_ready, lsu_req_ready}, 2'b10);
        push(0, 64'h0010_0073, 1);
        tick();
        ifu_req_valid = 0;
        do_mem(0, 64'h8000_0000, 0, 64'h0, 8'h0, 64'h0010_0073);

        // Tie: LSU first, IFU in the IDLE cycle after LSU's response
        ifu_req_valid = 1; ifu_addr = 64'h8000_0004;
        lsu_req_valid = 1; lsu_addr = 64'h8000_2000; lsu_we = 0;
        lsu_wdata = 64'hdead_beef_0000_0000; lsu_wmask = 8'hff;
        #1 check("tie_ready", {ifu_req_ready, lsu_req_ready}, 2'b01);
        push(1, 64'h1111_2222_3333_4444, 1);
        tick();
        lsu_req_valid = 0;
        do_mem(0, 64'h8000_2000, 0, 64'hdead_beef_0000_0000, 8'hff, 64'h1111_2222_3333_4444);
        #1 check("ifu_after_lsu_ready", {ifu_req_ready, lsu_req_ready}, 2'b10);
        push(0, 64'h5555_6666, 1);
        tick();
        ifu_req_valid = 0;
        do_mem(0, 64'h8000_0004, 0, 64'h0, 8'h0, 64'h5555_6666);

        // Repeated ties with both requesters always valid
        ifu_req_valid = 1; lsu_req_valid = 1;
        for (int k = 0; k < 3; k++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_lsu = (k % 2 == 0);
`else
            exp_lsu = 1'b1;
`endif
            #1 check("tie_loop_ready", {ifu_req_ready, lsu_req_ready}, {!exp_lsu, exp_lsu});
            push(exp_lsu, 64'hA0 + 64'(k), 1);
            tick();
            if (exp_lsu) lsu_req_valid = 0; else ifu_req_valid = 0;
            if (exp_lsu)
                do_mem(0, 64'h8000_2000, 0, 64'hdead_beef_0000_0000, 8'hff, 64'hA0 + 64'(k));
            else
                do_mem(0, 64'h8000_0004, 0, 64'h0, 8'h0, 64'hA0 + 64'(k));
            ifu_req_valid = 1; lsu_req_valid = 1;
        end
        ifu_req_valid = 0; lsu_req_valid = 0;
        tick();

        // Store with 4 stall cycles; lsu_rdata not checked
        lsu_req_valid = 1; lsu_addr = 64'h8000_1000; lsu_we = 1;
        lsu_wdata = 64'h8765_4321_1234_5678; lsu_wmask = 8'h03;
        #1 check("store_ready", {ifu_req_ready, lsu_req_ready}, 2'b01);
        push(1, 64'h0, 0);
        tick();
        lsu_req_valid = 0; lsu_we = 0; lsu_wdata = '0; lsu_wmask = '0;
        do_mem(4, 64'h8000_1000, 1, 64'h8765_4321_1234_5678, 8'h03, 64'hffff);

        // Stray responses in IDLE and ISSUE
        mem_resp_valid = 1; mem_rdata = 64'hbad;
        #1 check("stray_idle_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
        tick();
        mem_resp_valid = 0;
        #1 check("stray_idle_no_issue", mem_req_valid, 0);
        ifu_req_valid = 1; ifu_addr = 64'h8000_0040;
        #1 check("post_stray_ready", {ifu_req_ready, lsu_req_ready}, 2'b10);
        push(0, 64'h77, 1);
        tick();
        ifu_req_valid = 0;
        mem_resp_valid = 1;
        #1 check("stray_issue_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
        tick();
        mem_resp_valid = 0;
        #1 check("stray_issue_stays", mem_req_valid, 1);
        do_mem(0, 64'h8000_0040, 0, 64'h0, 8'h0, 64'h77);

        // Reset during WAIT, then a late response
        ifu_req_valid = 1; ifu_addr = 64'h8000_0080;
        tick();
        ifu_req_valid = 0; mem_req_ready = 1;
        tick();
        mem_req_ready = 0;
        rst = 1;
        tick();
        rst = 0;
        #1;
        check("rstw_mem_req_valid", mem_req_valid, 0);
        check("rstw_mem_fields", {mem_we, mem_wmask, mem_wdata}, 0);
        check("rstw_mem_addr", mem_addr, 0);
        check("rstw_outs", {ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid}, 0);
        tick();
        mem_resp_valid = 1; mem_rdata = 64'h1234;
        #1 check("late_resp_ignored", {ifu_resp_valid, lsu_resp_valid}, 0);
        tick();
        mem_resp_valid = 0; mem_rdata = '0;
        #1 check("late_resp_no_state", mem_req_valid, 0);

        tick(); tick();
        check("scoreboard_drained", 64'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, 64, address width in bits for both requesters and the memory port, SHALL be supported.
REQ-002 Parameter DATA_W, 64, data width in bits; the wmask width SHALL be DATA_W/8.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising clk edge.
REQ-005 ifu_req_valid  input  1  fetch read request; ifu_req_ready  output  1  request accepted.
REQ-006 ifu_addr  input  ADDR_W  fetch address; ifu_resp_valid  output  1; ifu_rdata  output  DATA_W.
REQ-007 lsu_req_valid  input  1  load or store request; lsu_req_ready  output  1  request accepted.
REQ-008 lsu_addr  input  ADDR_W; lsu_we  input  1  store; lsu_wdata  input  DATA_W; lsu_wmask  input  DATA_W/8.
REQ-009 lsu_resp_valid  output  1  read data or store acknowledge; lsu_rdata  output  DATA_W.
REQ-010 mem_req_valid  output  1; mem_req_ready  input  1; mem_addr  output  ADDR_W; mem_we  output  1.
REQ-011 mem_wdata  output  DATA_W; mem_wmask  output  DATA_W/8; mem_resp_valid  input  1; mem_rdata  input  DATA_W.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, ISSUE and WAIT, with at most one transaction outstanding.
REQ-013 In IDLE with at least one requester valid, the block SHALL assert ready to the winner in that cycle, latch its request, record the owner, and move to ISSUE.
REQ-014 Fetch requests SHALL be latched with we=0 and wmask=0.
REQ-015 Arbitration on a simultaneous request SHALL grant LSU first (fixed priority); the loser's ready SHALL stay 0 and it must hold valid.
REQ-016 ready SHALL never be asserted outside IDLE, and never to both requesters in the same cycle.
REQ-017 In ISSUE, mem_req_valid SHALL be 1 and mem_addr/we/wdata/wmask SHALL be driven from the latched request, stable until mem_req_ready=1; then the FSM SHALL move to WAIT.
REQ-018 In WAIT, on mem_resp_valid=1 the owner's resp_valid SHALL pulse in that same cycle, its rdata SHALL equal mem_rdata, and the FSM SHALL return to IDLE.
REQ-019 A store SHALL also wait for mem_resp_valid, which serves as its acknowledge; lsu_rdata is don't-care for stores.
REQ-020 mem_resp_valid in IDLE or ISSUE SHALL be ignored, with no state change and no resp_valid.
REQ-021 The non-owner's resp_valid SHALL be 0; rdata outputs SHALL be 0 when the matching resp_valid is 0.
REQ-022 Minimum transaction time SHALL be 3 cycles (grant, issue, response); back-to-back grants SHALL be possible from the IDLE cycle after a response.

Reset
REQ-023 rst=1 SHALL force IDLE, owner=LSU, latched request fields to 0, and all ready, valid and mem_* outputs to 0 in the following cycle.
REQ-024 Reset mid-transaction SHALL abandon the outstanding request; a late mem_resp_valid after reset SHALL be ignored per REQ-020.

Configuration
REQ-025 With macro MEM_ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL be granted to the requester not granted last, tracked by a last-grant register that resets to IFU so that LSU wins first.
REQ-026 Without MEM_ARB_ROUND_ROBIN_EN, fixed LSU priority per REQ-015 SHALL apply and the last-grant register SHALL not exist.

Structure
REQ-027 Package npc_mem_pkg SHALL hold the state enum (IDLE/ISSUE/WAIT), the owner enum (OWN_IFU/OWN_LSU) and the default ADDR_W/DATA_W constants.
REQ-028 Winner selection SHALL be one sub-module, mem_arb_pick: inputs are the two valids and last_grant; output is the winner; it is purely combinational.

Verification
REQ-029 IFU-only read of addr 0x80000000, mem_req_ready=1, response one cycle later with rdata 0x00100073 -> ifu_resp_valid asserted at cycle 3 with ifu_rdata=0x00100073.
REQ-030 IFU and LSU valid in the same cycle, fixed priority -> LSU granted first and IFU granted in the IDLE cycle after LSU's response; with RR, consecutive ties alternate starting with LSU.
REQ-031 LSU store to 0x80001000, wdata 0x8765432112345678, wmask 0x03, mem_req_ready low for 4 cycles -> mem_* fields stable for all 4 cycles, then lsu_resp_valid on the acknowledge.
REQ-032 mem_resp_valid pulsed in IDLE and in ISSUE -> no resp_valid on either requester and no state change.
REQ-033 rst asserted during WAIT, with a stray mem_resp_valid one cycle after reset releases -> all outputs 0 and both resp_valid outputs stay 0.
